// File: rtl/tdp18k_pkg.sv
// Shared types and widths for the TDP18K port arbiter.
//   ADDR_W/DATA_W/BE_W : RAM port widths (non-FIFO mode, 18-bit data, 9-bit bytes)
//   IDX_MAX_W          : widest requester index (up to 4 requesters)
//   ram_req_t          : one access as presented to the RAM port
//   rd_tag_t           : read-return tag carried alongside the RAM read latency
package tdp18k_pkg;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 18;
    localparam int BE_W      = 2;
    localparam int IDX_MAX_W = 2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } ram_req_t;

    typedef struct packed {
        logic                 vld;
        logic [IDX_MAX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/tdp18k_port_arbiter_rr.sv
// Round-robin winner search plus the rr pointer (and optional lock) state.
// Optional feature macro: TDP18K_ARB_LOCK_EN adds lock_i so that a requester
// can keep the grant over consecutive accepted beats.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   valid_i          per-requester request valid
//   lock_i           per-requester lock request (TDP18K_ARB_LOCK_EN only)
//   grant_o          one-hot grant, zero when nobody is valid
//   grant_idx_o      binary index of the winner
//   grant_vld_o      a grant is issued this cycle
module tdp18k_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] valid_i,
`ifdef TDP18K_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock_i,
`endif
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDXW-1:0]    grant_idx_o,
    output logic               grant_vld_o
);

    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] rr_idx;
    logic            rr_found;
    logic            hold;
    logic [IDXW-1:0] hold_idx;
    logic [IDXW-1:0] win_idx;
    logic            win_vld;

    // Search starts one past the last winner and wraps without ever
    // forming an index >= NUM_REQ.
    always_comb begin
        int cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!rr_found && valid_i[IDXW'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IDXW'(cand);
            end
        end
    end

`ifdef TDP18K_ARB_LOCK_EN
    logic            lock_q;
    logic [IDXW-1:0] lock_idx_q;

    // The previous beat's winner keeps the port while it stays valid and locked.
    assign hold     = lock_q && valid_i[lock_idx_q] && lock_i[lock_idx_q];
    assign hold_idx = lock_idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= win_vld && lock_i[win_idx];
            lock_idx_q <= win_idx;
        end
    end
`else
    assign hold     = 1'b0;
    assign hold_idx = '0;
`endif

    always_comb begin
        win_idx  = hold ? hold_idx : rr_idx;
        win_vld  = hold | rr_found;
        // A locked beat leaves the pointer where it was.
        rr_ptr_d = (rr_found && !hold) ? rr_idx : rr_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_ptr_q <= IDXW'(NUM_REQ - 1);
        else         rr_ptr_q <= rr_ptr_d;
    end

    assign grant_o     = win_vld ? (NUM_REQ'(1) << win_idx) : '0;
    assign grant_idx_o = win_idx;
    assign grant_vld_o = win_vld;

endmodule

// File: rtl/tdp18k_port_arbiter.sv
// Shares one TDP18K RAM port (non-FIFO mode) between NUM_REQ requesters.
// Round-robin grant, one access per clock, registered onto the RAM pins;
// read data returns to the issuer RD_LAT+2 cycles after accept, in order.
// Optional feature macro: TDP18K_ARB_LOCK_EN adds REQ_LOCK_i (grant lock).
// Ports:
//   CLK_i, RESET_ni                  clock, asynchronous active-low reset
//   REQ_VALID_i/REQ_READY_o          per-requester handshake (ready one-hot)
//   REQ_WE_i/ADDR_i/WDATA_i/BE_i     packed per-requester payload
//   REQ_LOCK_i                       grant lock (TDP18K_ARB_LOCK_EN only)
//   RSP_VALID_o/RSP_RDATA_o          one-hot read return, shared data bus
//   RAM_*                            registered RAM port pins, RAM_RDATA_i input
//   BUSY_o                           a read is somewhere between issue and return
module tdp18k_port_arbiter
    import tdp18k_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RD_LAT  = 1,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic                   CLK_i,
    input  logic                   RESET_ni,
    input  logic [NUM_REQ-1:0]     REQ_VALID_i,
    output logic [NUM_REQ-1:0]     REQ_READY_o,
    input  logic [NUM_REQ-1:0]     REQ_WE_i,
    input  logic [14*NUM_REQ-1:0]  REQ_ADDR_i,
    input  logic [18*NUM_REQ-1:0]  REQ_WDATA_i,
    input  logic [2*NUM_REQ-1:0]   REQ_BE_i,
`ifdef TDP18K_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]     REQ_LOCK_i,
`endif
    output logic [NUM_REQ-1:0]     RSP_VALID_o,
    output logic [17:0]            RSP_RDATA_o,
    output logic                   RAM_WEN_o,
    output logic                   RAM_REN_o,
    output logic [13:0]            RAM_ADDR_o,
    output logic [17:0]            RAM_WDATA_o,
    output logic [1:0]             RAM_BE_o,
    input  logic [17:0]            RAM_RDATA_i,
    output logic                   BUSY_o
);

    logic [NUM_REQ-1:0] gnt;
    logic [IDXW-1:0]    gnt_idx;
    logic               gnt_vld;
    ram_req_t           win_req;
    ram_req_t           ram_req_q;
    logic               strobe_q;
    logic [IDXW-1:0]    iss_idx_q;
    rd_tag_t            tag_q [RD_LAT];
    rd_tag_t            tag_out;
    logic [NUM_REQ-1:0] rsp_vld_q;
    logic [17:0]        rsp_rdata_q;

    tdp18k_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr (
        .clk_i       (CLK_i),
        .rst_ni      (RESET_ni),
        .valid_i     (REQ_VALID_i),
`ifdef TDP18K_ARB_LOCK_EN
        .lock_i      (REQ_LOCK_i),
`endif
        .grant_o     (gnt),
        .grant_idx_o (gnt_idx),
        .grant_vld_o (gnt_vld)
    );

    assign REQ_READY_o = gnt;

    always_comb begin
        win_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_req.we    = REQ_WE_i[i];
                win_req.addr  = REQ_ADDR_i[i*ADDR_W +: ADDR_W];
                win_req.wdata = REQ_WDATA_i[i*DATA_W +: DATA_W];
                win_req.be    = REQ_BE_i[i*BE_W +: BE_W];
            end
        end
    end

    // Payload holds across idle cycles; only the strobe drops.
    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            ram_req_q <= '0;
            strobe_q  <= 1'b0;
            iss_idx_q <= '0;
        end else begin
            strobe_q  <= gnt_vld;
            iss_idx_q <= gnt_idx;
            if (gnt_vld) ram_req_q <= win_req;
        end
    end

    // Both strobes come from one flag, so they can never be high together.
    assign RAM_WEN_o   = strobe_q &  ram_req_q.we;
    assign RAM_REN_o   = strobe_q & ~ram_req_q.we;
    assign RAM_ADDR_o  = ram_req_q.addr;
    assign RAM_WDATA_o = ram_req_q.wdata;
    assign RAM_BE_o    = ram_req_q.be;

    // Tag travels beside the RAM read so it lines up with valid RAM_RDATA_i.
    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{vld: RAM_REN_o, idx: IDX_MAX_W'(iss_idx_q)};
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[RD_LAT-1];

    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            rsp_vld_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_vld_q <= tag_out.vld ? (NUM_REQ'(1) << tag_out.idx) : '0;
            if (tag_out.vld) rsp_rdata_q <= RAM_RDATA_i;
        end
    end

    assign RSP_VALID_o = rsp_vld_q;
    assign RSP_RDATA_o = rsp_rdata_q;

    always_comb begin
        BUSY_o = RAM_REN_o;
        for (int i = 0; i < RD_LAT; i++) BUSY_o = BUSY_o | tag_q[i].vld;
    end

endmodule

// File: tb/tb_tdp18k_port_arbiter.sv
// Bench for tdp18k_port_arbiter: two instances (RD_LAT = 1 and 2) share the
// same requester stimulus; each has its own RAM model on the pins. Expected
// values come from a cycle-level reference model (round-robin rule, golden
// memory, response schedule by cycle number).
module tb_tdp18k_port_arbiter;

    localparam int NR   = 2;
    localparam int NDUT = 2;
    localparam int IW   = 1;
`ifdef TDP18K_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_we    = '0;
    logic [14*NR-1:0] req_addr  = '0;
    logic [18*NR-1:0] req_wdata = '0;
    logic [2*NR-1:0]  req_be    = '0;
    logic [NR-1:0]    req_lock  = '0;

    logic [NR-1:0] ready_o   [NDUT];
    logic [NR-1:0] rsp_vld_o [NDUT];
    logic [17:0]   rdata_o   [NDUT];
    logic          wen_o     [NDUT];
    logic          ren_o     [NDUT];
    logic [13:0]   addr_o    [NDUT];
    logic [17:0]   wdata_o   [NDUT];
    logic [1:0]    be_o      [NDUT];
    logic          busy_o    [NDUT];
    logic [17:0]   ram_rdata [NDUT];

    function automatic logic [17:0] init_word(int a);
        logic [17:0] w;
        if (a == 'h40) return 18'h1BEEF;
        w = 18'(a * 37) ^ 18'h0A5C3;
        return w;
    endfunction

    function automatic logic [17:0] merge(logic [17:0] o, logic [17:0] w, logic [1:0] be);
        logic [17:0] r;
        r = o;
        if (be[0]) r[8:0]  = w[8:0];
        if (be[1]) r[17:9] = w[17:9];
        return r;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [17:0] ram_mem [16384];
        bit          ram_wr  [16384];
        logic [17:0] rd_pipe [2];

        function automatic logic [17:0] rd_word(logic [13:0] a);
            return ram_wr[a] ? ram_mem[a] : init_word(int'(a));
        endfunction

        always @(posedge clk) begin
            if (wen_o[g]) begin
                ram_mem[addr_o[g]] <= merge(rd_word(addr_o[g]), wdata_o[g], be_o[g]);
                ram_wr[addr_o[g]]  <= 1'b1;
            end
            rd_pipe[0] <= ren_o[g] ? rd_word(addr_o[g]) : 18'($urandom);
            rd_pipe[1] <= rd_pipe[0];
        end

        assign ram_rdata[g] = rd_pipe[g];

        tdp18k_port_arbiter #(
            .NUM_REQ (NR),
            .RD_LAT  (g + 1)
        ) u_dut (
            .CLK_i       (clk),
            .RESET_ni    (rst_n),
            .REQ_VALID_i (req_valid),
            .REQ_READY_o (ready_o[g]),
            .REQ_WE_i    (req_we),
            .REQ_ADDR_i  (req_addr),
            .REQ_WDATA_i (req_wdata),
            .REQ_BE_i    (req_be),
`ifdef TDP18K_ARB_LOCK_EN
            .REQ_LOCK_i  (req_lock),
`endif
            .RSP_VALID_o (rsp_vld_o[g]),
            .RSP_RDATA_o (rdata_o[g]),
            .RAM_WEN_o   (wen_o[g]),
            .RAM_REN_o   (ren_o[g]),
            .RAM_ADDR_o  (addr_o[g]),
            .RAM_WDATA_o (wdata_o[g]),
            .RAM_BE_o    (be_o[g]),
            .RAM_RDATA_i (ram_rdata[g]),
            .BUSY_o      (busy_o[g])
        );
    end

    // ---------------- reference model state ----------------
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          rr_m;
    int          lock_own;
    int          last_w;
    logic [NR-1:0] obs_gnt;
    logic [17:0] gold     [16384];
    bit          gold_wr  [16384];
    bit          rd_acc   [16];
    logic [1:0]  exp_rv   [NDUT][16];
    logic [17:0] exp_rd   [NDUT][16];
    logic [17:0] exp_hold [NDUT];
    logic        exp_wen, exp_ren;
    logic [13:0] exp_addr;
    logic [17:0] exp_wdata;
    logic [1:0]  exp_be;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [17:0] gold_rd(logic [13:0] a);
        return gold_wr[a] ? gold[a] : init_word(int'(a));
    endfunction

    function automatic logic [13:0] pl_addr(int i);
        return (i == 0) ? req_addr[13:0] : req_addr[27:14];
    endfunction
    function automatic logic [17:0] pl_wdata(int i);
        return (i == 0) ? req_wdata[17:0] : req_wdata[35:18];
    endfunction
    function automatic logic [1:0] pl_be(int i);
        return (i == 0) ? req_be[1:0] : req_be[3:2];
    endfunction

    task automatic set_req(int i, bit v, bit we, logic [13:0] a, logic [17:0] d,
                           logic [1:0] be, bit lk);
        req_valid[IW'(i)] = v;
        req_we[IW'(i)]    = we;
        req_lock[IW'(i)]  = lk;
        if (i == 0) begin
            req_addr[13:0] = a; req_wdata[17:0] = d; req_be[1:0] = be;
        end else begin
            req_addr[27:14] = a; req_wdata[35:18] = d; req_be[3:2] = be;
        end
    endtask

    task automatic clear_model();
        rr_m = NR - 1;
        lock_own = -1;
        last_w = -1;
        exp_wen = 1'b0; exp_ren = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0;
        for (int k = 0; k < 16; k++) begin
            rd_acc[k] = 1'b0;
            for (int d = 0; d < NDUT; d++) begin
                exp_rv[d][k] = '0;
                exp_rd[d][k] = '0;
            end
        end
        for (int d = 0; d < NDUT; d++) exp_hold[d] = '0;
    endtask

    task automatic check_outputs();
        int  slot;
        bit  b;
        slot = cyc & 15;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("wen%0d", d),   32'(wen_o[d]),   32'(exp_wen));
            check($sformatf("ren%0d", d),   32'(ren_o[d]),   32'(exp_ren));
            check($sformatf("addr%0d", d),  32'(addr_o[d]),  32'(exp_addr));
            check($sformatf("wdata%0d", d), 32'(wdata_o[d]), 32'(exp_wdata));
            check($sformatf("be%0d", d),    32'(be_o[d]),    32'(exp_be));
            check($sformatf("rsp_vld%0d", d), 32'(rsp_vld_o[d]), 32'(exp_rv[d][slot]));
            if (exp_rv[d][slot] != '0) exp_hold[d] = exp_rd[d][slot];
            check($sformatf("rsp_data%0d", d), 32'(rdata_o[d]), 32'(exp_hold[d]));
            exp_rv[d][slot] = '0;
            b = 1'b0;
            for (int k = 1; k <= d + 2; k++) b = b | rd_acc[(cyc - k) & 15];
            check($sformatf("busy%0d", d), 32'(busy_o[d]), 32'(b));
        end
    endtask

    // One clock: check the grant at mid-cycle, advance the model, then check
    // the registered outputs just after the edge.
    task automatic run_cycle();
        int          w;
        bit          locked;
        bit          we;
        logic [13:0] a;
        logic [NR-1:0] eg;
        @(negedge clk);
        w = -1;
        locked = 1'b0;
        if (LOCK_EN && lock_own >= 0 && req_valid[IW'(lock_own)] && req_lock[IW'(lock_own)]) begin
            w = lock_own;
            locked = 1'b1;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                int i;
                i = (rr_m + k) % NR;
                if (w < 0 && req_valid[IW'(i)]) w = i;
            end
        end
        eg = (w >= 0) ? NR'(1 << w) : '0;
        obs_gnt = ready_o[0];
        for (int d = 0; d < NDUT; d++) check($sformatf("ready%0d", d), 32'(ready_o[d]), 32'(eg));
        rd_acc[cyc & 15] = 1'b0;
        if (w >= 0) begin
            we = req_we[IW'(w)];
            a  = pl_addr(w);
            exp_wen = we; exp_ren = !we;
            exp_addr = a; exp_wdata = pl_wdata(w); exp_be = pl_be(w);
            if (we) begin
                gold[a] = merge(gold_rd(a), pl_wdata(w), pl_be(w));
                gold_wr[a] = 1'b1;
            end else begin
                rd_acc[cyc & 15] = 1'b1;
                for (int d = 0; d < NDUT; d++) begin
                    exp_rv[d][(cyc + d + 3) & 15] = 2'(1 << w);
                    exp_rd[d][(cyc + d + 3) & 15] = gold_rd(a);
                end
            end
            if (!locked) rr_m = w;
            lock_own = (LOCK_EN && req_lock[IW'(w)]) ? w : -1;
        end else begin
            exp_wen = 1'b0; exp_ren = 1'b0;
            lock_own = -1;
        end
        last_w = w;
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_lock  = '0;
        rst_n = 1'b0;
        clear_model();
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("rst_wen",  32'(wen_o[d]),     32'd0);
            check("rst_ren",  32'(ren_o[d]),     32'd0);
            check("rst_addr", 32'(addr_o[d]),    32'd0);
            check("rst_rsp",  32'(rsp_vld_o[d]), 32'd0);
            check("rst_data", 32'(rdata_o[d]),   32'd0);
            check("rst_busy", 32'(busy_o[d]),    32'd0);
        end
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // single write from requester 0
        set_req(0, 1, 1, 14'h0010, 18'h2A5A5, 2'b11, 0);
        run_cycle();
        check("t1_wen",   32'(wen_o[0]),   32'd1);
        check("t1_ren",   32'(ren_o[0]),   32'd0);
        check("t1_addr",  32'(addr_o[0]),  32'h0010);
        check("t1_wdata", 32'(wdata_o[0]), 32'h2A5A5);
        check("t1_be",    32'(be_o[0]),    32'h3);
        set_req(0, 0, 0, 14'h0, 18'h0, 2'b00, 0);

        // requester 1 reads 0x0040; RD_LAT=2 instance returns 4 cycles later
        set_req(1, 1, 0, 14'h0040, 18'h0, 2'b00, 0);
        run_cycle();
        set_req(1, 0, 0, 14'h0040, 18'h0, 2'b00, 0);
        repeat (3) run_cycle();
        check("t3_rsp_vld", 32'(rsp_vld_o[1]), 32'h2);
        check("t3_rdata",   32'(rdata_o[1]),   32'h1BEEF);

        // both requesters hold reads: grants alternate 0,1,0,1
        set_req(0, 1, 0, 14'h0010, 18'h0, 2'b00, 0);
        set_req(1, 1, 0, 14'h0040, 18'h0, 2'b00, 0);
        for (int k = 0; k < 4; k++) begin
            run_cycle();
            check("t2_grant", 32'(obs_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        set_req(0, 0, 0, 14'h0, 18'h0, 2'b00, 0);
        set_req(1, 0, 0, 14'h0, 18'h0, 2'b00, 0);
        repeat (5) run_cycle();

        // reset one cycle after a read accept drops the response
        set_req(0, 1, 0, 14'h0040, 18'h0, 2'b00, 0);
        run_cycle();
        set_req(0, 0, 0, 14'h0, 18'h0, 2'b00, 0);
        do_reset();
        repeat (5) run_cycle();
        set_req(0, 1, 0, 14'h0003, 18'h0, 2'b00, 0);
        set_req(1, 1, 0, 14'h0004, 18'h0, 2'b00, 0);
        run_cycle();
        check("t4_first", 32'(obs_gnt), 32'h1);

`ifdef TDP18K_ARB_LOCK_EN
        // requester 1 locks for three beats while requester 0 waits
        set_req(1, 1, 1, 14'h0005, 18'h11111, 2'b01, 1);
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            check("lock_grant", 32'(obs_gnt), 32'h2);
        end
        set_req(1, 0, 0, 14'h0, 18'h0, 2'b00, 0);
        run_cycle();
        check("lock_release", 32'(obs_gnt), 32'h1);
`endif
        set_req(0, 0, 0, 14'h0, 18'h0, 2'b00, 0);
        set_req(1, 0, 0, 14'h0, 18'h0, 2'b00, 0);
        repeat (4) run_cycle();

        // random traffic; a requester keeps its request until granted
        for (int n = 0; n < 300; n++) begin
            if (n == 150) begin
                do_reset();
            end
            for (int i = 0; i < NR; i++) begin
                if (!(req_valid[IW'(i)] && last_w != i)) begin
                    logic [13:0] ra;
                    ra = 14'($urandom_range(0, 15)) | (($urandom_range(0, 1) != 0) ? 14'h0040 : 14'h0);
                    set_req(i, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), ra,
                            18'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end
            end
            run_cycle();
        end
        set_req(0, 0, 0, 14'h0, 18'h0, 2'b00, 0);
        set_req(1, 0, 0, 14'h0, 18'h0, 2'b00, 0);
        repeat (6) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
